// File: rtl/calc_disp_pkg.sv
// Shared status codes, FSM states and segment glyphs for the display driver.
package calc_disp_pkg;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        ERR    = 2'd3
    } state_e;

    // Active-low g..a patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h23;

    localparam int NUM_DIGITS = 8;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment (g..a) decoder; codes 10-15 are blank.
import calc_disp_pkg::*;

module seg7_decode (
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:    seg_o = 7'h40;
            4'd1:    seg_o = 7'h79;
            4'd2:    seg_o = 7'h24;
            4'd3:    seg_o = 7'h30;
            4'd4:    seg_o = 7'h19;
            4'd5:    seg_o = 7'h12;
            4'd6:    seg_o = 7'h02;
            4'd7:    seg_o = 7'h78;
            4'd8:    seg_o = 7'h00;
            4'd9:    seg_o = 7'h10;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_mux8.sv
// Eight-digit multiplexed display: shadow/active frame double buffer, scan refresh, error glyphs.
// Optional leading-zero blanking when DISP_LZB_EN is defined.
import calc_disp_pkg::*;

module disp_mux8 #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_commit
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_e                 state_q, state_d;
    logic [7:0][3:0]        shadow_q, active_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             scan_q;
    logic [7:0]             an_q, an_d, seg_q, seg_d;
    logic                   fc_q, commit;
    logic [7:0]             blank_lz;
    logic [6:0]             dec_pat;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE:    if (status == ST_BUSY)  state_d = LOAD;
            LOAD:    if (status == ST_READY) state_d = COMMIT;
            COMMIT:  begin
                state_d = IDLE;
                commit  = 1'b1;
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        // Error wins over every other transition
        if (status == ST_ERR) state_d = ERR;
    end

    // Digit i is blank when it and every digit above it are zero; digit 0 always shown
    always_comb begin
        logic nz;
        blank_lz = '0;
        nz       = 1'b0;
`ifdef DISP_LZB_EN
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            nz          = nz | (active_q[i] != 4'd0);
            blank_lz[i] = ~nz;
        end
`endif
    end

    seg7_decode u_dec (
        .code_i (active_q[scan_q]),
        .seg_o  (dec_pat)
    );

    always_comb begin
        logic [6:0] pat;
        pat = dec_pat;
        if (state_q == ERR) begin
            case (scan_q)
                3'd0:    pat = SEG_O;
                3'd1:    pat = SEG_R;
                3'd2:    pat = SEG_R;
                3'd3:    pat = SEG_E;
                default: pat = SEG_BLANK;
            endcase
        end else if (blank_lz[scan_q]) begin
            pat = SEG_BLANK;
        end
        seg_d = {1'b1, pat};
        an_d  = ~(8'd1 << scan_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            scan_q   <= '0;
            an_q     <= 8'hFF;
            seg_q    <= 8'hFF;
            fc_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= commit;
            if (state_q != ERR && !pos[3]) shadow_q[pos[2:0]] <= data;
            if (commit) active_q <= shadow_q;
            if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                cnt_q  <= '0;
                scan_q <= scan_q + 3'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an           = an_q;
    assign seg          = seg_q;
    assign frame_commit = fc_q;

endmodule
